multi_cycle_controller: RTL

- Multi-cycle control FSM for the MIPS-subset CPU; next generation of the single-cycle opcode decoder.
- Sequences every instruction through fetch/decode/execute/memory/writeback states and drives datapath enables per state, so one ALU and one unified memory are shared.
- Waits on memory with a ready handshake and counts retired instructions.

---
 rtl/multi_cycle_controller.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/multi_cycle_controller.sv
// Multi-cycle MIPS-subset control FSM: sequences fetch/decode/execute/memory/writeback
// and counts retired instructions. Optional macro ILLEGAL_OP_TRAP_EN adds a sticky TRAP state.
module multi_cycle_controller #(
  parameter int OPCODE_W = 6,
  parameter int ALU_OP_W = 3,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                pc_w,
  output logic                pc_w_cond,
  output logic                i_or_d,
  output logic                ir_w,
  output logic                mem_r,
  output logic                mem_w,
  output logic                mem_to_reg,
  output logic                reg_dst,
  output logic                reg_w,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [1:0]          pc_src,
  output logic                illegal,
  output logic [CNT_W-1:0]    retired
);

  localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(6'b000000);
  localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(6'b100011);
  localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(6'b101011);
  localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(6'b000100);
  localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'(6'b000010);
  localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(6'b001000);
  localparam logic [OPCODE_W-1:0] OP_ANDI = OPCODE_W'(6'b001100);
  localparam logic [OPCODE_W-1:0] OP_ORI  = OPCODE_W'(6'b001101);
  localparam logic [OPCODE_W-1:0] OP_SLTI = OPCODE_W'(6'b001010);

  localparam logic [ALU_OP_W-1:0] ALU_ADD   = ALU_OP_W'(3'b000);
  localparam logic [ALU_OP_W-1:0] ALU_SUB   = ALU_OP_W'(3'b001);
  localparam logic [ALU_OP_W-1:0] ALU_FUNCT = ALU_OP_W'(3'b010);
  localparam logic [ALU_OP_W-1:0] ALU_AND   = ALU_OP_W'(3'b011);
  localparam logic [ALU_OP_W-1:0] ALU_OR    = ALU_OP_W'(3'b100);
  localparam logic [ALU_OP_W-1:0] ALU_SLT   = ALU_OP_W'(3'b101);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    R_EXEC    = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    I_EXEC    = 4'd10,
    I_WB      = 4'd11
`ifdef ILLEGAL_OP_TRAP_EN
    , TRAP    = 4'd12
`endif
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  assign retired_d = retired_q + {{(CNT_W-1){1'b0}}, retire};
  assign retired   = retired_q;

  always_comb begin
    state_d    = state_q;
    retire     = 1'b0;
    pc_w       = 1'b0;
    pc_w_cond  = 1'b0;
    i_or_d     = 1'b0;
    ir_w       = 1'b0;
    mem_r      = 1'b0;
    mem_w      = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    reg_w      = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = ALU_ADD;
    pc_src     = 2'b00;
`ifdef ILLEGAL_OP_TRAP_EN
    illegal    = 1'b0;
`endif
    case (state_q)
      FETCH: begin
        mem_r     = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_w    = 1'b1;
          pc_w    = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        // ALU precomputes PC + (imm << 2) so BRANCH can use the ALU out register
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW:                     state_d = MEM_ADDR;
          OP_R:                             state_d = R_EXEC;
          OP_BEQ:                           state_d = BRANCH;
          OP_J:                             state_d = JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = I_EXEC;
`ifdef ILLEGAL_OP_TRAP_EN
          default:                          state_d = TRAP;
`else
          default:                          state_d = FETCH;
`endif
        endcase
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (opcode == OP_LW)      state_d = MEM_READ;
        else if (opcode == OP_SW) state_d = MEM_WRITE;
        else                      state_d = FETCH;
      end
      MEM_READ: begin
        mem_r  = 1'b1;
        i_or_d = 1'b1;
        if (mem_ready) state_d = MEM_WB;
      end
      MEM_WB: begin
        reg_w      = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = FETCH;
      end
      MEM_WRITE: begin
        mem_w  = 1'b1;
        i_or_d = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = FETCH;
        end
      end
      R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
        state_d   = R_WB;
      end
      R_WB: begin
        reg_w   = 1'b1;
        reg_dst = 1'b1;
        retire  = 1'b1;
        state_d = FETCH;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_w_cond = 1'b1;
        pc_src    = 2'b01;
        retire    = 1'b1;
        state_d   = FETCH;
      end
      JUMP: begin
        pc_w    = 1'b1;
        pc_src  = 2'b10;
        retire  = 1'b1;
        state_d = FETCH;
      end
      I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        case (opcode)
          OP_ANDI: alu_op = ALU_AND;
          OP_ORI:  alu_op = ALU_OR;
          OP_SLTI: alu_op = ALU_SLT;
          default: alu_op = ALU_ADD;
        endcase
        state_d = I_WB;
      end
      I_WB: begin
        reg_w   = 1'b1;
        retire  = 1'b1;
        state_d = FETCH;
      end
`ifdef ILLEGAL_OP_TRAP_EN
      TRAP: begin
        illegal = 1'b1;
        state_d = TRAP;
      end
`endif
      default: state_d = FETCH;
    endcase
  end

`ifndef ILLEGAL_OP_TRAP_EN
  assign illegal = 1'b0;
`endif

endmodule
